dfi_phy_responder: RTL and testbench
====================================

Name: dfi_phy_responder

Overview:
- Behavioural PHY-side DFI responder: the slave end of the DFI interface that the controller drives as master.
- Decodes DFI commands and tracks per-bank open rows.
- Captures write data into a small backing store and returns read data with the configured PHY read latency.
- Flags protocol errors. Used as the DFI termination in controller-level simulation and FPGA bring-up.

Parameters:
- C_DFI_ADDR_WIDTH, 16, width of dfi_address (row/column).
- C_BANK_WIDTH, 3, bank address width; 2**C_BANK_WIDTH banks tracked.
- C_DFI_DATA_WIDTH, 128, DFI data beat width.
- C_MEM_ROW_BITS, 2, low row bits used in store index.
- C_MEM_COL_BITS, 4, low column bits used in store index.
- C_CMDQ_DEPTH, 4, pending RD and pending WR queue depth each (power of 2).
- C_RDLAT, 3, cycles from dfi_rddata_en to dfi_rddata_valid (1..8).

Ports:
- core_clk  in  1  clock.
- core_arstn  in  1  asynchronous active-low reset.
- dfi_address  in  C_DFI_ADDR_WIDTH  row (ACT) / column (RD, WR); bit 10 = all-banks on PRE.
- dfi_bank  in  C_BANK_WIDTH  bank.
- dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n  in  1 each  command.
- dfi_cke  in  1  commands ignored when 0.
- dfi_wrdata_en  in  1  write beat valid.
- dfi_wrdata  in  C_DFI_DATA_WIDTH  write beat.
- dfi_wrdata_mask  in  C_DFI_DATA_WIDTH/8  byte mask, 1 = byte not written.
- dfi_rddata_en  in  1  read beat request.
- dfi_rddata  out  C_DFI_DATA_WIDTH  read beat.
- dfi_rddata_valid  out  1  read beat valid.
- err_clr  in  1  pulse, clears err.
- err  out  7  sticky error flags.

Behaviour:
- Reset: all banks closed; queues empty; dfi_rddata=0, dfi_rddata_valid=0, err=0. Store contents are not reset (X until written).
- Command decode, sampled when cs_n=0 and cke=1, {ras_n,cas_n,we_n}:
  - 111 NOP.
  - 011 ACT: open bank, latch row.
  - 101 RD: push {bank,row,col} to RD queue.
  - 100 WR: push to WR queue.
  - 010 PRE: close bank; close all banks if address[10]=1.
  - 001 REF: no state change.
  - 000 MRS: no state change.
  - 110 ZQ: ignored.
- cs_n=1 or cke=0: no effect.
- Store index = {row[C_MEM_ROW_BITS-1:0], bank, col[C_MEM_COL_BITS-1:0]}; row is the bank's latched open row. One beat per RD/WR command.
- Write path: on dfi_wrdata_en=1, pop WR queue head and write dfi_wrdata to the store with per-byte mask, in the same cycle.
- Read path: on dfi_rddata_en=1, pop RD queue head and read the store. Data appears on dfi_rddata with dfi_rddata_valid=1 exactly C_RDLAT cycles later via a shift pipeline. One beat per enable; back-to-back enables give back-to-back valids.
- Queue rules:
  - Push and pop in the same cycle: both occur, count unchanged.
  - Pop on an empty queue is an error even if a push occurs the same cycle.
  - Push on a full queue (no simultaneous pop): command dropped, error set.
- Error bits (sticky; err_clr clears; a new error in the same cycle as err_clr wins):
  - [0] ACT to an open bank (row is re-latched anyway).
  - [1] RD/WR to a closed bank (still queued, row taken as 0).
  - [2] REF or MRS while any bank is open.
  - [3] wrdata_en with WR queue empty (beat dropped).
  - [4] rddata_en with RD queue empty (valid still returned after C_RDLAT, data=0).
  - [5] queue overflow.
  - [6] timing violation.
- Reset mid-operation: pipeline, queues and bank states are flushed immediately; no valid emitted after reset.

Optional Feature:
- Macro DFI_RESP_TIMING_CHECK_EN.
- Defined:
  - Adds parameters C_TRCD=4 and C_TRP=4.
  - A per-bank counter is loaded on ACT/PRE.
  - RD/WR fewer than C_TRCD cycles after ACT to the same bank sets err[6].
  - ACT fewer than C_TRP cycles after PRE to the same bank sets err[6].
  - The command is still executed.
- Undefined: no counters; err[6] tied 0.

Test Plan:
- Single write: ACT bank2 row5, WR col3, wrdata_en with data 0xA5.. mask 0, then RD col3, rddata_en at T -> valid at T+3, data 0xA5.., err=0.
- Byte mask: write 0xFF..FF, then write 0x00.. with mask 0x..FE -> readback byte0=0x00, other bytes 0xFF.
- Back-to-back reads: 4 RDs (cols 0-3, distinct data), rddata_en held 4 cycles -> 4 consecutive valids in order; a 5th RD with queue full (no pop) -> err[5]=1.
- Protocol errors: RD to closed bank 1 -> err[1]; ACT twice to bank 0 -> err[0]; REF with bank 0 open -> err[2]; rddata_en with nothing pending -> err[4] and valid with data 0; err_clr -> err=0.
- PRE all (address[10]=1) after opening banks 0,3,7, then REF -> err[2] stays 0.
- Reset asserted one cycle after rddata_en -> dfi_rddata_valid stays 0; with macro defined, RD 2 cycles after ACT -> err[6]=1.

Source files
------------

// File: rtl/dfi_phy_responder.sv
// PHY-side DFI responder: decodes commands, tracks open rows, backs reads/writes with a small store.
// Optional tRCD/tRP checking is enabled by defining DFI_RESP_TIMING_CHECK_EN.

module dfi_resp_cmdq #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow
);
  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // A pop on an empty queue is refused even if a push lands in the same cycle.
  assign empty    = (count == '0);
  assign full     = (count == AW1'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign dout     = mem[rd_ptr];

  // NOTE: storage arrays carry no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop)
        count <= do_push ? count + AW1'(1) : count - AW1'(1);
    end
  end
endmodule

module dfi_phy_responder #(
  parameter int C_DFI_ADDR_WIDTH = 16,
  parameter int C_BANK_WIDTH     = 3,
  parameter int C_DFI_DATA_WIDTH = 128,
  parameter int C_MEM_ROW_BITS   = 2,
  parameter int C_MEM_COL_BITS   = 4,
  parameter int C_CMDQ_DEPTH     = 4,
  parameter int C_RDLAT          = 3
`ifdef DFI_RESP_TIMING_CHECK_EN
  ,
  parameter int C_TRCD           = 4,
  parameter int C_TRP            = 4
`endif
) (
  input  logic                          core_clk,
  input  logic                          core_arstn,
  input  logic [C_DFI_ADDR_WIDTH-1:0]   dfi_address,
  input  logic [C_BANK_WIDTH-1:0]       dfi_bank,
  input  logic                          dfi_cs_n,
  input  logic                          dfi_ras_n,
  input  logic                          dfi_cas_n,
  input  logic                          dfi_we_n,
  input  logic                          dfi_cke,
  input  logic                          dfi_wrdata_en,
  input  logic [C_DFI_DATA_WIDTH-1:0]   dfi_wrdata,
  input  logic [C_DFI_DATA_WIDTH/8-1:0] dfi_wrdata_mask,
  input  logic                          dfi_rddata_en,
  output logic [C_DFI_DATA_WIDTH-1:0]   dfi_rddata,
  output logic                          dfi_rddata_valid,
  input  logic                          err_clr,
  output logic [6:0]                    err
);
  localparam int NBANK  = 2 ** C_BANK_WIDTH;
  localparam int MASK_W = C_DFI_DATA_WIDTH / 8;
  localparam int IDX_W  = C_MEM_ROW_BITS + C_BANK_WIDTH + C_MEM_COL_BITS;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_ZQ  = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  cmd_e                         cmd;
  logic                         cmd_vld;
  logic                         is_act, is_pre, is_rd, is_wr, is_ref_mrs;
  logic [NBANK-1:0]             bank_open;
  logic [C_MEM_ROW_BITS-1:0]    bank_row [NBANK];
  logic [C_MEM_ROW_BITS-1:0]    cur_row;
  logic [IDX_W-1:0]             cmd_idx;
  logic [IDX_W-1:0]             rdq_head, wrq_head;
  logic                         rdq_empty, rdq_full, rdq_ovf;
  logic                         wrq_empty, wrq_full, wrq_ovf;
  logic [C_DFI_DATA_WIDTH-1:0]  store [2**IDX_W];
  logic [C_DFI_DATA_WIDTH-1:0]  rd_beat;
  logic [C_RDLAT-1:0]           pipe_vld;
  logic [C_DFI_DATA_WIDTH-1:0]  pipe_data [C_RDLAT];
  logic [6:0]                   err_set;
  logic                         timing_err;
  logic                         unused_addr;

  assign cmd_vld    = !dfi_cs_n && dfi_cke;
  assign cmd        = cmd_e'({dfi_ras_n, dfi_cas_n, dfi_we_n});
  assign is_act     = cmd_vld && (cmd == CMD_ACT);
  assign is_pre     = cmd_vld && (cmd == CMD_PRE);
  assign is_rd      = cmd_vld && (cmd == CMD_RD);
  assign is_wr      = cmd_vld && (cmd == CMD_WR);
  assign is_ref_mrs = cmd_vld && ((cmd == CMD_REF) || (cmd == CMD_MRS));

  // Only the low row/column bits reach the store; the rest of the address is don't-care.
  assign unused_addr = ^dfi_address;

  // A closed bank contributes row 0 to the store index.
  assign cur_row = bank_open[dfi_bank] ? bank_row[dfi_bank] : '0;
  assign cmd_idx = {cur_row, dfi_bank, dfi_address[C_MEM_COL_BITS-1:0]};

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      bank_open <= '0;
      for (int b = 0; b < NBANK; b++) bank_row[b] <= '0;
    end else if (is_act) begin
      bank_open[dfi_bank] <= 1'b1;
      bank_row[dfi_bank]  <= dfi_address[C_MEM_ROW_BITS-1:0];
    end else if (is_pre) begin
      if (dfi_address[10]) bank_open <= '0;
      else                 bank_open[dfi_bank] <= 1'b0;
    end
  end

  dfi_resp_cmdq #(.W(IDX_W), .DEPTH(C_CMDQ_DEPTH)) u_rdq (
    .clk(core_clk), .rst_n(core_arstn), .push(is_rd), .din(cmd_idx), .pop(dfi_rddata_en),
    .dout(rdq_head), .empty(rdq_empty), .full(rdq_full), .overflow(rdq_ovf)
  );

  dfi_resp_cmdq #(.W(IDX_W), .DEPTH(C_CMDQ_DEPTH)) u_wrq (
    .clk(core_clk), .rst_n(core_arstn), .push(is_wr), .din(cmd_idx), .pop(dfi_wrdata_en),
    .dout(wrq_head), .empty(wrq_empty), .full(wrq_full), .overflow(wrq_ovf)
  );

  always_ff @(posedge core_clk) begin
    if (dfi_wrdata_en && !wrq_empty) begin
      for (int b = 0; b < MASK_W; b++)
        if (!dfi_wrdata_mask[b]) store[wrq_head][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
    end
  end

  // An enable with nothing pending still produces a beat, carrying zero data.
  assign rd_beat = rdq_empty ? '0 : store[rdq_head];

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      pipe_vld <= '0;
      for (int i = 0; i < C_RDLAT; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= dfi_rddata_en;
      pipe_data[0] <= dfi_rddata_en ? rd_beat : '0;
      for (int i = 1; i < C_RDLAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign dfi_rddata       = pipe_data[C_RDLAT-1];
  assign dfi_rddata_valid = pipe_vld[C_RDLAT-1];

`ifdef DFI_RESP_TIMING_CHECK_EN
  localparam int T_MAX = (C_TRCD > C_TRP) ? C_TRCD : C_TRP;
  localparam int CNT_W = $clog2(T_MAX + 1);

  // Counter holds cycles remaining before the bank may take its next command class.
  logic [CNT_W-1:0] t_cnt [NBANK];

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      for (int b = 0; b < NBANK; b++) t_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (is_act && (dfi_bank == C_BANK_WIDTH'(b)))
          t_cnt[b] <= CNT_W'(C_TRCD - 1);
        else if (is_pre && (dfi_address[10] || (dfi_bank == C_BANK_WIDTH'(b))))
          t_cnt[b] <= CNT_W'(C_TRP - 1);
        else if (t_cnt[b] != '0)
          t_cnt[b] <= t_cnt[b] - CNT_W'(1);
      end
    end
  end

  // Open bank means the counter came from ACT (tRCD); closed means from PRE (tRP).
  assign timing_err = (t_cnt[dfi_bank] != '0) &&
                      (((is_rd || is_wr) && bank_open[dfi_bank]) ||
                       (is_act && !bank_open[dfi_bank]));
`else
  assign timing_err = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    err_set    = '0;
    err_set[0] = is_act && bank_open[dfi_bank];
    err_set[1] = (is_rd || is_wr) && !bank_open[dfi_bank];
    err_set[2] = is_ref_mrs && (|bank_open);
    err_set[3] = dfi_wrdata_en && wrq_empty;
    err_set[4] = dfi_rddata_en && rdq_empty;
    err_set[5] = rdq_ovf || wrq_ovf;
    err_set[6] = timing_err;
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) err <= '0;
    else             err <= (err_clr ? 7'd0 : err) | err_set;
  end
endmodule

// File: tb/tb_dfi_phy_responder.sv
// Self-checking bench for dfi_phy_responder: read beats are scoreboarded by data and arrival cycle.
// Define DFI_RESP_TIMING_CHECK_EN for both bench and RTL to exercise the timing checks.

module tb_dfi_phy_responder;
  localparam int RDLAT = 3;
  localparam logic [2:0] K_ACT = 3'b011, K_RD = 3'b101, K_WR = 3'b100, K_PRE = 3'b010;
  localparam logic [2:0] K_REF = 3'b001, K_NOP = 3'b111;

  logic         core_clk = 1'b0;
  logic         core_arstn;
  logic [15:0]  dfi_address;
  logic [2:0]   dfi_bank;
  logic         dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cke;
  logic         dfi_wrdata_en;
  logic [127:0] dfi_wrdata;
  logic [15:0]  dfi_wrdata_mask;
  logic         dfi_rddata_en;
  logic [127:0] dfi_rddata;
  logic         dfi_rddata_valid;
  logic         err_clr;
  logic [6:0]   err;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  dfi_phy_responder dut (
    .core_clk(core_clk), .core_arstn(core_arstn), .dfi_address(dfi_address), .dfi_bank(dfi_bank),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_cke(dfi_cke), .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata),
    .dfi_wrdata_mask(dfi_wrdata_mask), .dfi_rddata_en(dfi_rddata_en), .dfi_rddata(dfi_rddata),
    .dfi_rddata_valid(dfi_rddata_valid), .err_clr(err_clr), .err(err)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc++;

  // Each valid beat must match the oldest expectation in both data and cycle.
  always @(negedge core_clk) begin
    if (dfi_rddata_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: cyc=%0d data=%h required=no beat", cyc, dfi_rddata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dfi_rddata !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL rd_beat: data=%h cyc=%0d required data=%h cyc=%0d",
                   dfi_rddata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [15:0] a);
    @(negedge core_clk);
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = c;
    dfi_cs_n = 1'b0; dfi_bank = b; dfi_address = a;
    @(negedge core_clk);
    dfi_cs_n = 1'b1; {dfi_ras_n, dfi_cas_n, dfi_we_n} = K_NOP;
  endtask

  task automatic wbeat(input logic [127:0] d, input logic [15:0] m);
    @(negedge core_clk);
    dfi_wrdata_en = 1'b1; dfi_wrdata = d; dfi_wrdata_mask = m;
    @(negedge core_clk);
    dfi_wrdata_en = 1'b0;
  endtask

  task automatic rd_req(input logic [127:0] d);
    @(negedge core_clk);
    dfi_rddata_en = 1'b1;
    sb.push_back('{d, cyc + RDLAT});
    @(negedge core_clk);
    dfi_rddata_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge core_clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clr();
    @(negedge core_clk);
    err_clr = 1'b1;
    @(negedge core_clk);
    err_clr = 1'b0;
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL err_clr: err=%h required=00", err); end
  endtask

  task automatic apply_reset();
    @(negedge core_clk);
    core_arstn = 1'b0;
    idle(2);
    core_arstn = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    core_arstn = 1'b0;
    dfi_address = '0; dfi_bank = '0; dfi_cs_n = 1'b1; dfi_cke = 1'b1;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = K_NOP;
    dfi_wrdata_en = 1'b0; dfi_wrdata = '0; dfi_wrdata_mask = '0;
    dfi_rddata_en = 1'b0; err_clr = 1'b0;
    idle(3);
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL reset_err: err=%h required=00", err); end
    total++;
    if (dfi_rddata_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b required=0", dfi_rddata_valid); end
    total++;
    if (dfi_rddata !== '0) begin bad++; $display("FAIL reset_data: got=%h required=0", dfi_rddata); end
    core_arstn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_write();
    issue(K_ACT, 3'd2, 16'd5); idle(4);
    issue(K_WR, 3'd2, 16'd3);
    wbeat({16{8'hA5}}, 16'h0000);
    issue(K_RD, 3'd2, 16'd3);
    rd_req({16{8'hA5}});
    drain();
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL single_err: err=%h required=00", err); end
  endtask

  task automatic test_byte_mask();
    issue(K_WR, 3'd2, 16'd4);
    issue(K_WR, 3'd2, 16'd4);
    wbeat({16{8'hFF}}, 16'h0000);
    wbeat('0, 16'hFFFE);
    issue(K_RD, 3'd2, 16'd4);
    rd_req({{15{8'hFF}}, 8'h00});
    drain();
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL mask_err: err=%h required=00", err); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) issue(K_WR, 3'd2, 16'(i));
    for (int i = 0; i < 4; i++) wbeat({16{8'(8'h10 + i)}}, 16'h0000);
    for (int i = 0; i < 4; i++) issue(K_RD, 3'd2, 16'(i));
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL b2b_fill_err: err=%h required=00", err); end
    issue(K_RD, 3'd2, 16'd5);
    total++;
    if (err !== 7'h20) begin bad++; $display("FAIL b2b_overflow: err=%h required=20", err); end
    for (int i = 0; i < 4; i++) begin
      @(negedge core_clk);
      dfi_rddata_en = 1'b1;
      sb.push_back('{{16{8'(8'h10 + i)}}, cyc + RDLAT});
    end
    @(negedge core_clk);
    dfi_rddata_en = 1'b0;
    drain();
    total++;
    if (err !== 7'h20) begin bad++; $display("FAIL b2b_err_after: err=%h required=20", err); end
    clr();
  endtask

  task automatic test_protocol_errors();
    issue(K_PRE, 3'd0, 16'h0400); idle(4);
    issue(K_WR, 3'd1, 16'd0);
    total++;
    if (err !== 7'h02) begin bad++; $display("FAIL wr_closed: err=%h required=02", err); end
    wbeat({8{16'hBEEF}}, 16'h0000);
    issue(K_RD, 3'd1, 16'd0);
    rd_req({8{16'hBEEF}});
    drain();
    clr();
    issue(K_ACT, 3'd0, 16'd1); idle(4);
    issue(K_ACT, 3'd0, 16'd1);
    total++;
    if (err !== 7'h01) begin bad++; $display("FAIL act_open: err=%h required=01", err); end
    clr();
    issue(K_REF, 3'd0, 16'd0);
    total++;
    if (err !== 7'h04) begin bad++; $display("FAIL ref_open: err=%h required=04", err); end
    @(negedge core_clk);
    err_clr = 1'b1; dfi_cs_n = 1'b0; {dfi_ras_n, dfi_cas_n, dfi_we_n} = K_REF;
    @(negedge core_clk);
    err_clr = 1'b0; dfi_cs_n = 1'b1; {dfi_ras_n, dfi_cas_n, dfi_we_n} = K_NOP;
    total++;
    if (err !== 7'h04) begin bad++; $display("FAIL clr_vs_new: err=%h required=04", err); end
    clr();
    rd_req('0);
    total++;
    if (err !== 7'h10) begin bad++; $display("FAIL rd_empty: err=%h required=10", err); end
    drain();
    clr();
    wbeat({16{8'h77}}, 16'h0000);
    total++;
    if (err !== 7'h08) begin bad++; $display("FAIL wr_empty: err=%h required=08", err); end
    clr();
  endtask

  task automatic test_pre_all();
    issue(K_PRE, 3'd0, 16'h0400); idle(4);
    issue(K_ACT, 3'd0, 16'd2); idle(4);
    issue(K_ACT, 3'd3, 16'd2); idle(4);
    issue(K_ACT, 3'd7, 16'd2); idle(4);
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL pre_all_acts: err=%h required=00", err); end
    issue(K_PRE, 3'd5, 16'h0400); idle(4);
    issue(K_REF, 3'd0, 16'd0);
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL pre_all_ref: err=%h required=00", err); end
  endtask

  task automatic test_reset_mid_read();
    int stray = 0;
    issue(K_ACT, 3'd2, 16'd5); idle(4);
    issue(K_RD, 3'd2, 16'd3);
    issue(K_RD, 3'd2, 16'd3);
    @(negedge core_clk);
    dfi_rddata_en = 1'b1;
    @(negedge core_clk);
    dfi_rddata_en = 1'b0;
    core_arstn = 1'b0;
    idle(2);
    core_arstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge core_clk);
      if (dfi_rddata_valid !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL reset_flush_valid: beats=%0d required=0", stray); end
    rd_req('0);
    total++;
    if (err !== 7'h10) begin bad++; $display("FAIL reset_flush_queue: err=%h required=10", err); end
    drain();
    issue(K_RD, 3'd2, 16'd3);
    total++;
    if (err !== 7'h12) begin bad++; $display("FAIL reset_flush_banks: err=%h required=12", err); end
  endtask

`ifdef DFI_RESP_TIMING_CHECK_EN
  task automatic test_timing();
    apply_reset();
    issue(K_ACT, 3'd4, 16'd0);
    issue(K_RD, 3'd4, 16'd0);
    total++;
    if (err !== 7'h40) begin bad++; $display("FAIL trcd_early: err=%h required=40", err); end
    clr();
    idle(4);
    issue(K_WR, 3'd4, 16'd1);
    total++;
    if (err !== 7'h00) begin bad++; $display("FAIL trcd_met: err=%h required=00", err); end
    issue(K_PRE, 3'd4, 16'd0);
    issue(K_ACT, 3'd4, 16'd0);
    total++;
    if (err !== 7'h40) begin bad++; $display("FAIL trp_early: err=%h required=40", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_byte_mask();
    test_back_to_back();
    test_protocol_errors();
    test_pre_all();
    test_reset_mid_read();
`ifdef DFI_RESP_TIMING_CHECK_EN
    test_timing();
`endif
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
